sdram_wb_arbiter: RTL and testbench
===================================

SDRAM_WB_ARBITER -- requirements
Module: sdram_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, Wishbone data width in bytes.
REQ-002 SHALL have parameter MAX_BURST, default 64, maximum sel'd accesses per grant before forced re-arbitration.
REQ-003 SHALL have port sys_clk  input  1  system clock, 100 MHz; one clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wshb_ifs_0  wshb_if.slave  -  requester 0 (video read stream).
REQ-006 SHALL have port wshb_ifs_1  wshb_if.slave  -  requester 1 (writer/CPU side).
REQ-007 SHALL have port wshb_ifm  wshb_if.master  -  shared SDRAM Wishbone port.
REQ-008 SHALL have port grant  output  2  one-hot current owner, 00 = none.

Function
REQ-009 SHALL implement FSM states IDLE, GNT0, GNT1; grant = {GNT1, GNT0}.
REQ-010 IDLE: requester with cyc=1 SHALL be granted on the next edge; if both request, winner per REQ-017.
REQ-011 In GNTx, wshb_ifm cyc/stb/we/adr/dat_ms/sel/cti/bte SHALL equal requester x's, same cycle (combinational mux, no added latency).
REQ-012 In IDLE, wshb_ifm cyc and stb SHALL be 0; other master outputs 0.
REQ-013 Owner SHALL receive ack/err/rty from wshb_ifm unchanged; non-owner SHALL receive ack=err=rty=0; dat_sm SHALL be broadcast to both.
REQ-014 Release: in GNTx, when cyc_x=0 at a clock edge, FSM SHALL move to the other GNT state if the other requester has cyc=1, else IDLE; no idle cycle between owners.
REQ-015 A burst counter SHALL count acks in GNTx; when it reaches MAX_BURST and the other requester has cyc=1, FSM SHALL switch at the edge after that ack while stb/ack closes the transfer (no cycle split mid-transfer: switch only on a cycle with ack=1).
REQ-016 Burst counter SHALL clear on every grant change; saturate at MAX_BURST; width $clog2(MAX_BURST+1).
REQ-017 Simultaneous requests from IDLE: winner per Configuration; a single requester always wins immediately.
REQ-018 A requester dropping cyc while not owner SHALL have no effect on state.
REQ-019 err or rty to owner SHALL not change state; release still only via REQ-014/015.

Reset
REQ-020 sys_rst=1 SHALL asynchronously force IDLE, grant=00, wshb_ifm cyc=stb=0, burst counter=0, last-owner=1 (so requester 0 wins first tie).
REQ-021 Reset mid-transfer SHALL drop master cyc immediately; no ack forwarded to either requester while sys_rst=1.

Configuration
REQ-022 Macro ARB_ROUND_ROBIN_EN defined: ties SHALL go to the requester not last granted (last-owner register updated on each grant); forced switch of REQ-015 active.
REQ-023 Macro ARB_ROUND_ROBIN_EN undefined: ties SHALL always go to requester 0 (fixed priority); REQ-015 forced switch applies only when owner is requester 1.

Structure
REQ-024 Package sdram_arb_pkg SHALL hold the FSM state enum (arb_state_t) and grant encoding constants.
REQ-025 Sub-module sdram_arb_fsm SHALL hold the FSM, burst counter and last-owner register; top sdram_wb_arbiter holds only the muxes.

Verification
REQ-026 Only req0 cyc=1 from IDLE, 4 single reads with slave ack after 2 cycles -> grant=01 next edge, 4 acks to req0, req1 sees ack=0, IDLE after cyc0 drops.
REQ-027 Both cyc=1 same cycle after reset -> grant=01 first; req0 drops cyc -> grant=10 on next edge with no IDLE cycle.
REQ-028 ARB_ROUND_ROBIN_EN, MAX_BURST=4, both hold cyc continuously with ack every cycle -> grant alternates 01/10 every 4 acks; without macro, req0 holds grant indefinitely.
REQ-029 sys_rst pulsed mid-burst of req1 -> grant=00 and master cyc=0 same cycle, no ack to req1; after release, pending req0 granted first.
REQ-030 Owner receives err=1 -> forwarded to owner only, grant unchanged until owner drops cyc.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg -- shared definitions for the two-requester SDRAM Wishbone
// arbiter.
//   arb_state_t : arbiter FSM state. The encoding equals the one-hot grant
//                 vector {GNT1, GNT0}, so the state drives grant directly.
//   GRANT_*     : grant encodings seen on the arbiter's grant output.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

endpackage

// File: rtl/wshb_if.sv
// wshb_if -- Wishbone B4 classic bus bundle.
// Parameters: DATA_BYTES (data width in bytes), ADR_W (address width).
// Modports:
//   master : drives cyc/stb/we/adr/dat_ms/sel/cti/bte, receives ack/err/rty/dat_sm
//   slave  : the mirror image
// Handshake: a transfer is offered while cyc=1 and stb=1 and completes on the
// cycle the slave raises exactly one of ack/err/rty; the master holds all
// request fields stable until then. cyc=1 frames a bus ownership period that
// may cover several transfers.
interface wshb_if #(
  parameter int DATA_BYTES = 4,
  parameter int ADR_W      = 32
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADR_W-1:0]        adr;
  logic [8*DATA_BYTES-1:0] dat_ms;
  logic [DATA_BYTES-1:0]   sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;
  logic                    rty;
  logic [8*DATA_BYTES-1:0] dat_sm;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  ack, err, rty, dat_sm
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output ack, err, rty, dat_sm
  );
endinterface

// File: rtl/sdram_arb_fsm.sv
// sdram_arb_fsm -- ownership FSM for the SDRAM Wishbone arbiter.
// Holds the IDLE/GNT0/GNT1 state, the per-grant ack counter and (in the
// round-robin build) the last-owner register.
// Ports:
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   cyc0, cyc1       : bus-cycle requests from requester 0 / 1
//   ack              : ack returned by the shared SDRAM port
//   state            : current FSM state (equals the one-hot grant)
// Build option: ARB_ROUND_ROBIN_EN -- ties from IDLE go to the requester not
// granted last, and the burst cap can pre-empt either owner. Without it ties
// go to requester 0 and only requester 1 can be pre-empted by the cap.
module sdram_arb_fsm
  import sdram_arb_pkg::*;
#(
  parameter int MAX_BURST = 64
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cyc0,
  input  logic       cyc1,
  input  logic       ack,
  output arb_state_t state
);

  localparam int              CNT_W      = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t       state_nx;
  logic [CNT_W-1:0] burst_cnt;
  logic             cap_hit;
  logic             tie_pick1;
  logic             force_from0;

  // The cap fires on the ack that completes the MAX_BURST-th transfer (or any
  // later ack once saturated), so a switch never splits a transfer.
  assign cap_hit = ack && (burst_cnt >= BURST_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  assign tie_pick1   = (last_owner == 1'b0);
  assign force_from0 = 1'b1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      last_owner <= 1'b1;
    end else if (state_nx == GNT0) begin
      last_owner <= 1'b0;
    end else if (state_nx == GNT1) begin
      last_owner <= 1'b1;
    end
  end
`else
  assign tie_pick1   = 1'b0;
  assign force_from0 = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cyc0 && cyc1) begin
          state_nx = tie_pick1 ? GNT1 : GNT0;
        end else if (cyc0) begin
          state_nx = GNT0;
        end else if (cyc1) begin
          state_nx = GNT1;
        end
      end
      GNT0: begin
        if (!cyc0) begin
          state_nx = cyc1 ? GNT1 : IDLE;
        end else if (force_from0 && cap_hit && cyc1) begin
          state_nx = GNT1;
        end
      end
      GNT1: begin
        if (!cyc1) begin
          state_nx = cyc0 ? GNT0 : IDLE;
        end else if (cap_hit && cyc0) begin
          state_nx = GNT0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Counts acks delivered to the current owner; restarts on any grant change
  // and saturates so a long uncontended burst cannot wrap it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      burst_cnt <= '0;
    end else if (state_nx != state) begin
      burst_cnt <= '0;
    end else if ((state != IDLE) && ack && (burst_cnt != BURST_MAX)) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter -- shares one SDRAM Wishbone port between two requesters.
// Ports:
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   wshb_ifs_0       : requester 0 (video read stream), slave side
//   wshb_ifs_1       : requester 1 (writer/CPU side), slave side
//   wshb_ifm         : shared SDRAM port, master side
//   grant            : one-hot current owner {req1, req0}, 00 = none
// Parameters: DATA_BYTES (bus width in bytes), MAX_BURST (acks per grant
// before a waiting requester can take over).
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking and a
// symmetric burst cap (see sdram_arb_fsm).
// The request path is a purely combinational mux on the current grant, so the
// owner sees no extra latency; responses go back only to the owner while read
// data is broadcast.
module sdram_wb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int MAX_BURST  = 64
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  wshb_if.slave      wshb_ifs_0,
  wshb_if.slave      wshb_ifs_1,
  wshb_if.master     wshb_ifm,
  output logic [1:0] grant
);

  localparam logic [8*DATA_BYTES-1:0] DAT_ZERO = '0;
  localparam logic [DATA_BYTES-1:0]   SEL_ZERO = '0;

  arb_state_t arb_state;
  logic       own0;
  logic       own1;

  sdram_arb_fsm #(
    .MAX_BURST (MAX_BURST)
  ) u_fsm (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .cyc0    (wshb_ifs_0.cyc),
    .cyc1    (wshb_ifs_1.cyc),
    .ack     (wshb_ifm.ack),
    .state   (arb_state)
  );

  assign grant = arb_state;
  assign own0  = (arb_state == GNT0);
  assign own1  = (arb_state == GNT1);

  // Request mux: idle (and reset, which forces IDLE) drives all zeros.
  assign wshb_ifm.cyc    = own0 ? wshb_ifs_0.cyc    : own1 ? wshb_ifs_1.cyc    : 1'b0;
  assign wshb_ifm.stb    = own0 ? wshb_ifs_0.stb    : own1 ? wshb_ifs_1.stb    : 1'b0;
  assign wshb_ifm.we     = own0 ? wshb_ifs_0.we     : own1 ? wshb_ifs_1.we     : 1'b0;
  assign wshb_ifm.adr    = own0 ? wshb_ifs_0.adr    : own1 ? wshb_ifs_1.adr    : '0;
  assign wshb_ifm.dat_ms = own0 ? wshb_ifs_0.dat_ms : own1 ? wshb_ifs_1.dat_ms : DAT_ZERO;
  assign wshb_ifm.sel    = own0 ? wshb_ifs_0.sel    : own1 ? wshb_ifs_1.sel    : SEL_ZERO;
  assign wshb_ifm.cti    = own0 ? wshb_ifs_0.cti    : own1 ? wshb_ifs_1.cti    : 3'b000;
  assign wshb_ifm.bte    = own0 ? wshb_ifs_0.bte    : own1 ? wshb_ifs_1.bte    : 2'b00;

  // Response demux: only the owner sees termination strobes.
  assign wshb_ifs_0.ack = own0 & wshb_ifm.ack;
  assign wshb_ifs_0.err = own0 & wshb_ifm.err;
  assign wshb_ifs_0.rty = own0 & wshb_ifm.rty;
  assign wshb_ifs_1.ack = own1 & wshb_ifm.ack;
  assign wshb_ifs_1.err = own1 & wshb_ifm.err;
  assign wshb_ifs_1.rty = own1 & wshb_ifm.rty;

  assign wshb_ifs_0.dat_sm = wshb_ifm.dat_sm;
  assign wshb_ifs_1.dat_sm = wshb_ifm.dat_sm;

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_wb_arbiter;

  localparam int DB = 4;
  localparam int MB = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] grant;

  int n_checks = 0;
  int n_errors = 0;
  int acks_seen;

  wshb_if #(.DATA_BYTES(DB)) s0_if ();
  wshb_if #(.DATA_BYTES(DB)) s1_if ();
  wshb_if #(.DATA_BYTES(DB)) m_if ();

  sdram_wb_arbiter #(
    .DATA_BYTES (DB),
    .MAX_BURST  (MB)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .wshb_ifs_0 (s0_if),
    .wshb_ifs_1 (s1_if),
    .wshb_ifm   (m_if),
    .grant      (grant)
  );

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Inputs change 2 ns after the rising edge; checks follow 1 ns later.
  task automatic next_cycle();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input int idx, input logic cyc, input logic [31:0] adr);
    if (idx == 0) begin
      s0_if.cyc = cyc; s0_if.stb = cyc; s0_if.we = 1'b0; s0_if.adr = adr;
      s0_if.dat_ms = 32'h0; s0_if.sel = 4'hf; s0_if.cti = 3'b000; s0_if.bte = 2'b00;
    end else begin
      s1_if.cyc = cyc; s1_if.stb = cyc; s1_if.we = 1'b1; s1_if.adr = adr;
      s1_if.dat_ms = 32'hcafe_0000 | adr; s1_if.sel = 4'hf; s1_if.cti = 3'b000; s1_if.bte = 2'b00;
    end
  endtask

  task automatic drive_resp(input logic ack, input logic err, input logic rty, input logic [31:0] dat);
    m_if.ack = ack; m_if.err = err; m_if.rty = rty; m_if.dat_sm = dat;
  endtask

  task automatic do_reset();
    drive_req(0, 1'b0, 32'h0);
    drive_req(1, 1'b0, 32'h0);
    drive_resp(1'b0, 1'b0, 1'b0, 32'h0);
    sys_rst = 1'b1;
    next_cycle();
    sys_rst = 1'b0;
    settle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0] exp_g;

    // reset state
    drive_req(0, 1'b0, 32'h0);
    drive_req(1, 1'b0, 32'h0);
    drive_resp(1'b0, 1'b0, 1'b0, 32'h0);
    sys_rst = 1'b1;
    #3;
    check("rst_grant", grant, 2'b00);
    check("rst_mcyc", m_if.cyc, 1'b0);
    check("rst_mstb", m_if.stb, 1'b0);

    // single requester 0, four reads acked after two wait cycles
    drive_req(0, 1'b1, 32'h0000_1000);
    next_cycle();
    check("rst_hold_grant", grant, 2'b00);
    sys_rst = 1'b0;
    settle();
    check("idle_mcyc", m_if.cyc, 1'b0);
    check("idle_madr", m_if.adr, 32'h0);
    next_cycle();
    check("r0_grant", grant, 2'b01);
    check("r0_mcyc", m_if.cyc, 1'b1);
    check("r0_madr", m_if.adr, 32'h0000_1000);
    acks_seen = 0;
    for (int i = 0; i < 4; i++) begin
      drive_req(0, 1'b1, 32'h0000_1000 + 32'(4 * i));
      settle();
      check("r0_wait_ack", s0_if.ack, 1'b0);
      next_cycle();
      next_cycle();
      drive_resp(1'b1, 1'b0, 1'b0, 32'hd000_0000 + 32'(i));
      settle();
      if (s0_if.ack) acks_seen++;
      check("r0_ack1_zero", s1_if.ack, 1'b0);
      check("r0_madr_rd", m_if.adr, 32'h0000_1000 + 32'(4 * i));
      check("r0_dat0", s0_if.dat_sm, 32'hd000_0000 + 32'(i));
      check("r0_dat1", s1_if.dat_sm, 32'hd000_0000 + 32'(i));
      next_cycle();
      drive_resp(1'b0, 1'b0, 1'b0, 32'h0);
    end
    check("r0_ack_count", 64'(acks_seen), 64'd4);
    check("r0_hold_grant", grant, 2'b01);
    drive_req(0, 1'b0, 32'h0);
    settle();
    check("r0_drop_mcyc", m_if.cyc, 1'b0);
    next_cycle();
    check("r0_release", grant, 2'b00);

    // simultaneous requests, hand-over without idle cycle, err/rty, non-owner drop
    do_reset();
    drive_req(0, 1'b1, 32'h0000_0100);
    drive_req(1, 1'b1, 32'h0000_0200);
    settle();
    check("tie_pre_grant", grant, 2'b00);
    next_cycle();
    check("tie_grant", grant, 2'b01);
    check("tie_madr", m_if.adr, 32'h0000_0100);
    check("tie_mwe", m_if.we, 1'b0);
    drive_req(0, 1'b0, 32'h0);
    settle();
    check("handover_pre", grant, 2'b01);
    next_cycle();
    check("handover_grant", grant, 2'b10);
    check("handover_madr", m_if.adr, 32'h0000_0200);
    check("handover_mwe", m_if.we, 1'b1);
    check("handover_mdat", m_if.dat_ms, 32'hcafe_0200);
    drive_resp(1'b0, 1'b1, 1'b0, 32'h0);
    settle();
    check("err_owner", s1_if.err, 1'b1);
    check("err_other", s0_if.err, 1'b0);
    check("err_noack", s1_if.ack, 1'b0);
    next_cycle();
    check("err_grant", grant, 2'b10);
    drive_resp(1'b0, 1'b0, 1'b1, 32'h0);
    settle();
    check("rty_owner", s1_if.rty, 1'b1);
    check("rty_other", s0_if.rty, 1'b0);
    next_cycle();
    check("rty_grant", grant, 2'b10);
    drive_resp(1'b0, 1'b0, 1'b0, 32'h0);
    drive_req(0, 1'b1, 32'h0000_0300);
    next_cycle();
    check("nonowner_req", grant, 2'b10);
    drive_req(0, 1'b0, 32'h0);
    next_cycle();
    check("nonowner_drop", grant, 2'b10);
    drive_req(1, 1'b0, 32'h0);
    next_cycle();
    check("r1_release", grant, 2'b00);

    // both requesters hold cyc, ack every cycle
    do_reset();
    drive_req(0, 1'b1, 32'h0000_0010);
    drive_req(1, 1'b1, 32'h0000_0020);
    drive_resp(1'b1, 1'b0, 1'b0, 32'h1234_5678);
    for (int k = 0; k < 12; k++) begin
      next_cycle();
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      check($sformatf("burst_k%0d", k), grant, exp_g);
    end

    // burst cap pre-empts requester 1 in both builds
    do_reset();
    drive_req(1, 1'b1, 32'h0000_0040);
    next_cycle();
    check("cap1_grant", grant, 2'b10);
    drive_req(0, 1'b1, 32'h0000_0030);
    drive_resp(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      check($sformatf("cap1_hold_k%0d", k), grant, 2'b10);
    end
    next_cycle();
    check("cap1_switch", grant, 2'b01);

    // reset pulse in the middle of a requester 1 burst
    do_reset();
    drive_req(1, 1'b1, 32'h0000_0050);
    next_cycle();
    check("rstmid_grant", grant, 2'b10);
    drive_resp(1'b1, 1'b0, 1'b0, 32'h0000_abcd);
    next_cycle();
    drive_req(0, 1'b1, 32'h0000_0060);
    settle();
    check("rstmid_ack_before", s1_if.ack, 1'b1);
    settle();
    sys_rst = 1'b1;
    settle();
    check("rstmid_grant0", grant, 2'b00);
    check("rstmid_mcyc", m_if.cyc, 1'b0);
    check("rstmid_ack1", s1_if.ack, 1'b0);
    check("rstmid_ack0", s0_if.ack, 1'b0);
    next_cycle();
    check("rstmid_hold", grant, 2'b00);
    sys_rst = 1'b0;
    drive_resp(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    check("rstmid_rel", grant, 2'b00);
    next_cycle();
    check("rstmid_first", grant, 2'b01);
    check("rstmid_madr", m_if.adr, 32'h0000_0060);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
